// File: rtl/pair_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pair_queue_pkg
//  Description : Shared constants, filter-word field layout and the pair
//                payload struct used by the pair_queue block.
//  Revision    : 1.0 - initial release
// ============================================================================
package pair_queue_pkg;

    // Filter word geometry
    localparam int FILTER_W = 227;
    localparam int PAIR_W   = 226;
    localparam int NULL_BIT = 226;

    // Field offsets / widths within the 226-bit payload
    localparam int REF_CELL_LSB = 218;
    localparam int REF_CELL_W   = 8;
    localparam int REF_ID_LSB   = 209;
    localparam int REF_ID_W     = 9;
    localparam int REF_POS_LSB  = 113;
    localparam int REF_POS_W    = 96;
    localparam int NB_CELL_LSB  = 105;
    localparam int NB_CELL_W    = 8;
    localparam int NB_ID_LSB    = 96;
    localparam int NB_ID_W      = 9;
    localparam int NB_POS_LSB   = 0;
    localparam int NB_POS_W     = 96;

    // Payload, MSB first (matches bits [225:0] of the filter word)
    typedef struct packed {
        logic [REF_CELL_W-1:0] ref_cell;
        logic [REF_ID_W-1:0]   ref_id;
        logic [REF_POS_W-1:0]  ref_pos;
        logic [NB_CELL_W-1:0]  nb_cell;
        logic [NB_ID_W-1:0]    nb_id;
        logic [NB_POS_W-1:0]   nb_pos;
    } pair_t;

    // Lane-index width; a single lane still gets a 1-bit source field
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // 32-bit add that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pair_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : pair_queue_if
//  Description : Valid/ready pair stream from pair_queue to the force
//                pipeline.
//                pair_valid - pair_data holds a pair
//                pair_ready - sink accepts this cycle
//                pair_data  - 226-bit pair payload (null bit stripped)
//                pair_src   - lane that produced pair_data
//                master modport: queue side; slave modport: pipeline side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pair_queue_if
    import pair_queue_pkg::*;
#(
    parameter int NUM_FILTERS = 4
) ();

    localparam int SRC_W = src_width(NUM_FILTERS);

    logic             pair_valid;
    logic             pair_ready;
    pair_t            pair_data;
    logic [SRC_W-1:0] pair_src;

    modport master (
        output pair_valid,
        output pair_data,
        output pair_src,
        input  pair_ready
    );

    modport slave (
        input  pair_valid,
        input  pair_data,
        input  pair_src,
        output pair_ready
    );

endinterface
`default_nettype wire

// File: rtl/pair_lane_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pair_lane_fifo
//  Description : Single-lane FIFO of pair payloads. Register array with
//                wrapping read/write pointers and an occupancy count.
//                clk, rst      - clock, asynchronous active-high reset
//                i_push/i_data - write request and payload
//                i_pop         - read request (head consumed this edge)
//                o_data        - head entry (valid when !o_empty)
//                o_count       - current occupancy
//                o_full/o_empty- occupancy flags
//                o_almost_full - occupancy after this edge >= DEPTH-AF_MARGIN
//  Revision    : 1.0 - initial release
// ============================================================================
module pair_lane_fifo #(
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2,
    parameter int WIDTH     = 226
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_do_pop;
    logic             w_do_push;
    logic [CNT_W-1:0] w_count_next;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A full lane still takes a push when its head leaves in the same edge:
    // the freed slot is reused and the count stays put.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // Looks at the post-edge occupancy so the registered stall lines up
    // with the state it describes.
    assign o_almost_full = (w_count_next >= CNT_W'(DEPTH - AF_MARGIN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pair_queue.sv
`default_nettype none
// ============================================================================
//  Module      : pair_queue
//  Description : Collects filter-lane outputs, drops null words, buffers
//                surviving pairs per lane and merges them round-robin into
//                one valid/ready stream.
//                fast_clk  - clock (all state on posedge)
//                reset     - asynchronous active-high reset
//                filter_in - NUM_FILTERS x 227-bit filter words
//                stall     - registered almost-full to pair generator
//                overflow  - sticky, a non-null word was lost
//                idle      - all lanes empty and no pair presented
//                pq        - pair stream (master modport)
//                Optional build macro PAIR_QUEUE_STATS_EN adds saturating
//                accepted_count / null_count / dropped_count outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module pair_queue
    import pair_queue_pkg::*;
#(
    parameter int NUM_FILTERS = 4,
    parameter int DEPTH       = 8,
    parameter int AF_MARGIN   = 2
) (
    input  logic                          fast_clk,
    input  logic                          reset,
    input  logic [NUM_FILTERS*FILTER_W-1:0] filter_in,
    output logic                          stall,
    output logic                          overflow,
    output logic                          idle,
    pair_queue_if.master                  pq
`ifdef PAIR_QUEUE_STATS_EN
    ,
    output logic [31:0]                   accepted_count,
    output logic [31:0]                   null_count,
    output logic [31:0]                   dropped_count
`endif
);

    localparam int SRC_W = src_width(NUM_FILTERS);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Lane signals
    logic [NUM_FILTERS-1:0] w_push_req;
    logic [NUM_FILTERS-1:0] w_pop;
    logic [NUM_FILTERS-1:0] w_drop;
    logic [NUM_FILTERS-1:0] w_full;
    logic [NUM_FILTERS-1:0] w_empty;
    logic [NUM_FILTERS-1:0] w_af;
    logic [PAIR_W-1:0]      w_head  [NUM_FILTERS];
    logic [CNT_W-1:0]       w_count [NUM_FILTERS];

    // Arbiter / output register
    logic                   w_load;
    logic                   w_grant_vld;
    logic [SRC_W-1:0]       w_grant;
    logic [PAIR_W-1:0]      w_sel_data;
    int                     w_dist;
    int                     w_best;
    logic                   w_all_empty;

    logic                   r_valid;
    pair_t                  r_data;
    logic [SRC_W-1:0]       r_src;
    logic [SRC_W-1:0]       r_rr_ptr;
    logic                   r_stall;
    logic                   r_overflow;

    assign w_load = ~r_valid | pq.pair_ready;

    for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_lane
        assign w_push_req[g] = ~filter_in[g*FILTER_W + NULL_BIT];
        assign w_pop[g]      = w_load & w_grant_vld & (w_grant == SRC_W'(g));
        // Lost word: lane full and not freeing a slot on this edge
        assign w_drop[g]     = w_push_req[g] & w_full[g] & ~w_pop[g];

        pair_lane_fifo #(
            .DEPTH     (DEPTH),
            .AF_MARGIN (AF_MARGIN),
            .WIDTH     (PAIR_W)
        ) u_fifo (
            .clk           (fast_clk),
            .rst           (reset),
            .i_push        (w_push_req[g]),
            .i_pop         (w_pop[g]),
            .i_data        (filter_in[g*FILTER_W +: PAIR_W]),
            .o_data        (w_head[g]),
            .o_count       (w_count[g]),
            .o_full        (w_full[g]),
            .o_empty       (w_empty[g]),
            .o_almost_full (w_af[g])
        );
    end

    // Round-robin pick: each lane's distance from rr_ptr+1 (mod lanes);
    // the non-empty lane with the smallest distance wins. Uses registered
    // occupancy, so a word written this edge is eligible only next edge.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_sel_data  = '0;
        w_best      = NUM_FILTERS;
        w_dist      = 0;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            w_dist = (i + NUM_FILTERS - 1 - int'(r_rr_ptr)) % NUM_FILTERS;
            if (!w_empty[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_grant_vld = 1'b1;
                w_grant     = SRC_W'(i);
                w_sel_data  = w_head[i];
            end
        end
    end

    always_comb begin
        w_all_empty = 1'b1;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (w_count[i] != '0) begin
                w_all_empty = 1'b0;
            end
        end
    end

    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_src    <= '0;
            r_rr_ptr <= SRC_W'(NUM_FILTERS - 1);
        end else if (w_load) begin
            r_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_data   <= w_sel_data;
                r_src    <= w_grant;
                r_rr_ptr <= w_grant;
            end
        end
    end

    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_stall <= |w_af;
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign pq.pair_valid = r_valid;
    assign pq.pair_data  = r_data;
    assign pq.pair_src   = r_src;
    assign stall         = r_stall;
    assign overflow      = r_overflow;
    assign idle          = w_all_empty & ~r_valid;

`ifdef PAIR_QUEUE_STATS_EN
    logic [31:0] r_accepted;
    logic [31:0] r_nulls;
    logic [31:0] r_dropped;

    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            r_accepted <= '0;
            r_nulls    <= '0;
            r_dropped  <= '0;
        end else begin
            r_accepted <= sat_add32(r_accepted, 32'($countones(w_push_req & ~w_drop)));
            r_nulls    <= sat_add32(r_nulls, 32'($countones(~w_push_req)));
            r_dropped  <= sat_add32(r_dropped, 32'($countones(w_drop)));
        end
    end

    assign accepted_count = r_accepted;
    assign null_count     = r_nulls;
    assign dropped_count  = r_dropped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pair_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pair_queue
//  Description : Self-checking bench for pair_queue: directed scenarios plus
//                randomized traffic compared against a queue-based model.
//                Honours PAIR_QUEUE_STATS_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pair_queue;
    import pair_queue_pkg::*;

    localparam int NF    = 4;
    localparam int DEPTH = 8;
    localparam int AFM   = 2;

    logic                   fast_clk = 1'b0;
    logic                   reset    = 1'b1;
    logic [NF*FILTER_W-1:0] filter_in;
    logic                   stall;
    logic                   overflow;
    logic                   idle;
`ifdef PAIR_QUEUE_STATS_EN
    logic [31:0]            accepted_count;
    logic [31:0]            null_count;
    logic [31:0]            dropped_count;
`endif

    pair_queue_if #(.NUM_FILTERS(NF)) pq_if ();

    pair_queue #(
        .NUM_FILTERS (NF),
        .DEPTH       (DEPTH),
        .AF_MARGIN   (AFM)
    ) dut (
        .fast_clk  (fast_clk),
        .reset     (reset),
        .filter_in (filter_in),
        .stall     (stall),
        .overflow  (overflow),
        .idle      (idle),
        .pq        (pq_if)
`ifdef PAIR_QUEUE_STATS_EN
        ,
        .accepted_count (accepted_count),
        .null_count     (null_count),
        .dropped_count  (dropped_count)
`endif
    );

    always #5 fast_clk = ~fast_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    pair_t  mq [NF][$];
    logic   m_valid;
    pair_t  m_data;
    int     m_src;
    int     m_rr;
    logic   m_ovf;
    logic   m_stall;
    int     m_acc;
    int     m_null;
    int     m_drop;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic pair_t rand_pair();
        logic [255:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return r[PAIR_W-1:0];
    endfunction

    task automatic model_reset();
        for (int l = 0; l < NF; l++) mq[l].delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_rr    = NF - 1;
        m_ovf   = 1'b0;
        m_stall = 1'b0;
        m_acc   = 0;
        m_null  = 0;
        m_drop  = 0;
    endtask

    // One posedge: pop (from pre-edge contents) then per-lane pushes.
    task automatic model_step();
        logic  found;
        pair_t w;
        if (!m_valid || pq_if.pair_ready) begin
            found = 1'b0;
            for (int off = 1; off <= NF; off++) begin
                int l;
                l = (m_rr + off) % NF;
                if (!found && mq[l].size() > 0) begin
                    found  = 1'b1;
                    m_data = mq[l].pop_front();
                    m_src  = l;
                    m_rr   = l;
                end
            end
            m_valid = found;
        end
        for (int l = 0; l < NF; l++) begin
            if (filter_in[l*FILTER_W + NULL_BIT]) begin
                m_null++;
            end else if (mq[l].size() < DEPTH) begin
                w = filter_in[l*FILTER_W +: PAIR_W];
                mq[l].push_back(w);
                m_acc++;
            end else begin
                m_ovf = 1'b1;
                m_drop++;
            end
        end
        m_stall = 1'b0;
        for (int l = 0; l < NF; l++) begin
            if (mq[l].size() >= DEPTH - AFM) m_stall = 1'b1;
        end
    endtask

    task automatic check_all();
        logic m_idle;
        m_idle = !m_valid;
        for (int l = 0; l < NF; l++) begin
            if (mq[l].size() != 0) m_idle = 1'b0;
        end
        check_eq("pair_valid", pq_if.pair_valid, m_valid);
        if (m_valid) begin
            check_eq("pair_data", pq_if.pair_data, m_data);
            check_eq("pair_src", pq_if.pair_src, m_src);
        end
        check_eq("stall", stall, m_stall);
        check_eq("overflow", overflow, m_ovf);
        check_eq("idle", idle, m_idle);
`ifdef PAIR_QUEUE_STATS_EN
        check_eq("accepted_count", accepted_count, m_acc);
        check_eq("null_count", null_count, m_null);
        check_eq("dropped_count", dropped_count, m_drop);
`endif
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic tick();
        @(posedge fast_clk);
        model_step();
        #1;
        check_all();
        @(negedge fast_clk);
    endtask

    task automatic all_null();
        for (int l = 0; l < NF; l++) filter_in[l*FILTER_W +: FILTER_W] = {1'b1, {PAIR_W{1'b0}}};
    endtask

    task automatic set_pair(input int l, input pair_t p);
        filter_in[l*FILTER_W +: FILTER_W] = {1'b0, p};
    endtask

    // Reset asserted between posedges; outputs must clear at once.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_pair_valid", pq_if.pair_valid, 1'b0);
        check_eq("rst_pair_data", pq_if.pair_data, '0);
        check_eq("rst_pair_src", pq_if.pair_src, '0);
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_idle", idle, 1'b1);
        model_reset();
        all_null();
        pq_if.pair_ready = 1'b0;
        @(posedge fast_clk);
        @(negedge fast_clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        pair_t p;
        pair_t held_data;
        logic [7:0] held_src;

        pq_if.pair_ready = 1'b0;
        all_null();
        model_reset();
        repeat (2) @(posedge fast_clk);
        @(negedge fast_clk);
        check_eq("init_pair_valid", pq_if.pair_valid, 1'b0);
        check_eq("init_stall", stall, 1'b0);
        check_eq("init_idle", idle, 1'b1);
        reset = 1'b0;

        // Null filtering
        pq_if.pair_ready = 1'b1;
        repeat (3) tick();
        p = rand_pair();
        p.ref_id = 9'd5;
        p.nb_id  = 9'd9;
        set_pair(2, p);
        tick();
        check_eq("nf_valid_at_k", pq_if.pair_valid, 1'b0);
        all_null();
        tick();
        check_eq("nf_valid", pq_if.pair_valid, 1'b1);
        check_eq("nf_src", pq_if.pair_src, 2);
        check_eq("nf_ref_id", pq_if.pair_data.ref_id, 5);
        check_eq("nf_nb_id", pq_if.pair_data.nb_id, 9);
`ifdef PAIR_QUEUE_STATS_EN
        check_eq("nf_null_count", null_count, 19);
`endif

        // Round-robin
        do_reset();
        pq_if.pair_ready = 1'b1;
        for (int l = 0; l < NF; l++) set_pair(l, rand_pair());
        tick();
        all_null();
        for (int s = 0; s < NF; s++) begin
            tick();
            check_eq("rr_valid", pq_if.pair_valid, 1'b1);
            check_eq("rr_src", pq_if.pair_src, s);
        end
        tick();
        check_eq("rr_end_valid", pq_if.pair_valid, 1'b0);
        check_eq("rr_end_idle", idle, 1'b1);

        // Backpressure hold
        do_reset();
        set_pair(0, rand_pair());
        set_pair(1, rand_pair());
        tick();
        all_null();
        tick();
        held_data = pq_if.pair_data;
        held_src  = 8'(pq_if.pair_src);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("bp_hold_valid", pq_if.pair_valid, 1'b1);
            check_eq("bp_hold_data", pq_if.pair_data, held_data);
            check_eq("bp_hold_src", pq_if.pair_src, held_src);
        end
        pq_if.pair_ready = 1'b1;
        tick();
        check_eq("bp_release_src", pq_if.pair_src, 1);
        tick();
        check_eq("bp_drained", pq_if.pair_valid, 1'b0);

        // Stall and overflow on lane 1
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            set_pair(1, rand_pair());
            tick();
            check_eq("so_stall", stall, (n >= 7));
            check_eq("so_overflow", overflow, (n >= 10));
        end
`ifdef PAIR_QUEUE_STATS_EN
        check_eq("so_dropped", dropped_count, 1);
`endif
        all_null();
        pq_if.pair_ready = 1'b1;
        repeat (12) tick();
        check_eq("so_overflow_sticky", overflow, 1'b1);

        // Full lane popped and pushed in the same cycle
        do_reset();
        for (int n = 0; n < 9; n++) begin
            set_pair(0, rand_pair());
            tick();
        end
        check_eq("fp_pre_stall", stall, 1'b1);
        pq_if.pair_ready = 1'b1;
        set_pair(0, rand_pair());
        tick();
        check_eq("fp_overflow", overflow, 1'b0);
        check_eq("fp_stall", stall, 1'b1);
        all_null();
        repeat (12) tick();

        // Reset mid-burst
        do_reset();
        for (int n = 0; n < 7; n++) begin
            for (int l = 0; l < NF; l++) set_pair(l, rand_pair());
            tick();
        end
        check_eq("rb_pre_stall", stall, 1'b1);
        do_reset();
        repeat (3) tick();
        check_eq("rb_idle", idle, 1'b1);
        check_eq("rb_valid", pq_if.pair_valid, 1'b0);

        // Random traffic, upstream honours stall
        for (int c = 0; c < 600; c++) begin
            pq_if.pair_ready = ($urandom_range(0, 3) != 0);
            for (int l = 0; l < NF; l++) begin
                if (!stall && $urandom_range(0, 1) == 1) set_pair(l, rand_pair());
                else filter_in[l*FILTER_W +: FILTER_W] = {1'b1, rand_pair()};
            end
            tick();
        end

        // Random traffic ignoring stall, sparse ready: provokes drops
        for (int c = 0; c < 200; c++) begin
            pq_if.pair_ready = ($urandom_range(0, 3) == 0);
            for (int l = 0; l < NF; l++) begin
                if ($urandom_range(0, 1) == 1) set_pair(l, rand_pair());
                else filter_in[l*FILTER_W +: FILTER_W] = {1'b1, rand_pair()};
            end
            tick();
        end

        all_null();
        pq_if.pair_ready = 1'b1;
        repeat (40) tick();
        check_eq("final_idle", idle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
